mdu_iter: RTL and testbench

Iterative multiply/divide unit for the execute stage of the lab CPU. It sits beside the combinational ALU, takes the same two register-file operands, and computes 32×32 signed/unsigned products and quotient/remainder pairs into architectural HI/LO registers over multiple cycles. While it runs it raises `busy`, and the control unit stalls dependent instructions (mfhi/mflo, a new mult/div) until `done`. It also provides the mthi/mtlo write path into HI/LO.

---
 rtl/mdu_iter.sv | 154 +++++++++++++++
 tb/tb_mdu_iter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
// Iterative 32x32 multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, then a sign-fix cycle.
module mdu_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [5:0] LastIter = 6'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e               state_q, state_d;
    logic [5:0]           cnt_q, cnt_d;
    logic [1:0]           op_q, op_d;
    logic                 neg_res_q, neg_res_d;
    logic                 neg_rem_q, neg_rem_d;
    logic                 dbz_q, dbz_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    logic                 is_signed, a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       add_sum, rem_sh, trial;
    logic [2*WIDTH-1:0]   mul_next, div_next, prod_fix;
    logic [WIDTH-1:0]     quo_fix, rem_fix;

    assign is_signed = ~op[0];
    assign a_neg     = is_signed & a[WIDTH-1];
    assign b_neg     = is_signed & b[WIDTH-1];
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;

    // Multiply: acc holds {partial product, remaining multiplier bits}.
    assign add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    assign mul_next = acc_q[0] ? {add_sum, acc_q[WIDTH-1:1]}
                               : {1'b0, acc_q[2*WIDTH-1:1]};

    // Divide: acc holds {partial remainder, dividend bits / quotient bits}.
    assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign trial    = rem_sh - {1'b0, opnd_q};
    assign div_next = trial[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                   : {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    assign prod_fix = neg_res_q ? -acc_q : acc_q;
    assign quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dbz_d     = dbz_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    op_d      = op;
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    cnt_d     = '0;
                    dbz_d     = 1'b0;
                    if (op[1] && (b == '0)) begin
                        hi_d    = a;
                        lo_d    = '1;
                        dbz_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        opnd_d  = op[1] ? b_mag : a_mag;
                        acc_d   = {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
                        state_d = StCalc;
                    end
                end else begin
                    state_d = StIdle;
                    dbz_d   = 1'b0;
                    if (wr_hi) hi_d = wdata;
                    if (wr_lo) lo_d = wdata;
                end
            end
            StCalc: begin
                acc_d = op_q[1] ? div_next : mul_next;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == LastIter) begin
                    cnt_d   = '0;
                    state_d = StFix;
                end
            end
            StFix: begin
                if (op_q[1]) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            op_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
            acc_q     <= '0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dbz_q     <= dbz_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy        = (state_q == StCalc) || (state_q == StFix);
    assign done        = (state_q == StDone);
    assign div_by_zero = (state_q == StDone) && dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter: arithmetic reference model checked every cycle, plus directed literals.
module tb_mdu_iter;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = '0;
    logic [31:0] a = '0, b = '0, wdata = '0;
    logic        wr_hi = 1'b0, wr_lo = 1'b0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    mdu_iter #(.WIDTH(32)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .start      (start),
        .op         (op),
        .a          (a),
        .b          (b),
        .wr_hi      (wr_hi),
        .wr_lo      (wr_lo),
        .wdata      (wdata),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference results straight from SystemVerilog integer arithmetic.
    function automatic void golden(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                   output logic [31:0] h, output logic [31:0] l);
        longint sx, sy, p, q, r;
        logic [63:0] pu;
        sx = longint'(int'(x));
        sy = longint'(int'(y));
        case (o)
            2'd0: begin p = sx * sy; h = p[63:32]; l = p[31:0]; end
            2'd1: begin pu = {32'b0, x} * {32'b0, y}; h = pu[63:32]; l = pu[31:0]; end
            2'd2: begin q = sx / sy; r = sx % sy; h = r[31:0]; l = q[31:0]; end
            default: begin h = x % y; l = x / y; end
        endcase
    endfunction

    int          m_left = 0;
    logic        m_done = 0, m_dbz = 0;
    logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            m_left = 0; m_done = 0; m_dbz = 0; m_hi = 0; m_lo = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_hi = p_hi; m_lo = p_lo; m_done = 1;
            end
        end else if (start) begin
            if (op[1] && b == 0) begin
                m_hi = a; m_lo = 32'hFFFF_FFFF; m_done = 1; m_dbz = 1;
            end else begin
                golden(op, a, b, p_hi, p_lo);
                m_left = 33; m_done = 0; m_dbz = 0;
            end
        end else begin
            m_done = 0; m_dbz = 0;
            if (wr_hi) m_hi = wdata;
            if (wr_lo) m_lo = wdata;
        end
    end

    always @(posedge clock) begin
        #1;
        check("cyc_busy", 64'(busy), 64'(m_left > 0));
        check("cyc_done", 64'(done), 64'(m_done));
        check("cyc_dbz", 64'(div_by_zero), 64'(m_dbz));
        check("cyc_hi", 64'(hi), 64'(m_hi));
        check("cyc_lo", 64'(lo), 64'(m_lo));
    end

    logic        l_busy, l_done, l_dbz;
    logic [31:0] l_hi, l_lo;
    int          nb;

    task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clock);
        #1;
        l_busy = busy; l_done = done; l_dbz = div_by_zero; l_hi = hi; l_lo = lo;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic run_done(output int n);
        n = int'(l_busy);
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (busy) n++;
            if (done) return;
        end
        total++;
        bad++;
        $display("FAIL done_timeout: got no done within 40 cycles, expected done");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at 100us");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clock);
        check("rst_hi", 64'(hi), 64'h0);
        check("rst_lo", 64'(lo), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_done", 64'(done), 64'h0);
        resetn = 1'b1;
        @(negedge clock);

        launch(2'd0, 32'hFFFF_FFFD, 32'd7);
        run_done(nb);
        check("mult_busy_cycles", 64'(nb), 64'd33);
        check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
        check("mult_lo", 64'(lo), 64'hFFFF_FFEB);
        @(negedge clock);

        launch(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_done(nb);
        check("multu_hi", 64'(hi), 64'hFFFF_FFFE);
        check("multu_lo", 64'(lo), 64'h1);
        launch(2'd1, 32'd2, 32'd3);
        check("b2b_accept_busy", 64'(l_busy), 64'h1);
        run_done(nb);
        check("b2b_busy_cycles", 64'(nb), 64'd33);
        check("b2b_hi", 64'(hi), 64'h0);
        check("b2b_lo", 64'(lo), 64'd6);
        @(negedge clock);

        launch(2'd2, 32'hFFFF_FFF9, 32'd2);
        run_done(nb);
        check("div_lo", 64'(lo), 64'hFFFF_FFFD);
        check("div_hi", 64'(hi), 64'hFFFF_FFFF);
        @(negedge clock);
        launch(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        run_done(nb);
        check("div_ovf_lo", 64'(lo), 64'h8000_0000);
        check("div_ovf_hi", 64'(hi), 64'h0);
        @(negedge clock);

        launch(2'd3, 32'd5, 32'd0);
        check("dbz_done", 64'(l_done), 64'h1);
        check("dbz_flag", 64'(l_dbz), 64'h1);
        check("dbz_busy", 64'(l_busy), 64'h0);
        check("dbz_hi", 64'(l_hi), 64'd5);
        check("dbz_lo", 64'(l_lo), 64'hFFFF_FFFF);
        @(posedge clock);
        #1;
        check("dbz_flag_clear", 64'(div_by_zero), 64'h0);
        check("dbz_done_clear", 64'(done), 64'h0);

        @(negedge clock);
        wr_hi = 1'b1; wdata = 32'h1234_5678;
        @(posedge clock);
        #1;
        check("mthi", 64'(hi), 64'h1234_5678);
        @(negedge clock);
        wr_hi = 1'b0;

        op = 2'd0; a = 32'd3; b = 32'd4; start = 1'b1;
        repeat (5) @(negedge clock);
        wr_lo = 1'b1; wdata = 32'hDEAD_BEEF;
        repeat (5) @(negedge clock);
        check("mtlo_busy_ignored", 64'(lo), 64'hFFFF_FFFF);
        wr_lo = 1'b0; start = 1'b0;
        l_busy = 1'b0;
        run_done(nb);
        check("held_start_hi", 64'(hi), 64'h0);
        check("held_start_lo", 64'(lo), 64'd12);
        @(negedge clock);

        wr_lo = 1'b1; wdata = 32'hFFFF_0000;
        launch(2'd1, 32'd5, 32'd5);
        wr_lo = 1'b0;
        check("start_beats_mtlo", 64'(l_lo), 64'd12);
        run_done(nb);
        check("multu5x5_lo", 64'(lo), 64'd25);
        @(negedge clock);

        launch(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (9) @(posedge clock);
        #3;
        resetn = 1'b0;
        #1;
        check("async_rst_busy", 64'(busy), 64'h0);
        check("async_rst_done", 64'(done), 64'h0);
        check("async_rst_dbz", 64'(div_by_zero), 64'h0);
        check("async_rst_hi", 64'(hi), 64'h0);
        check("async_rst_lo", 64'(lo), 64'h0);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        launch(2'd3, 32'd100, 32'd7);
        run_done(nb);
        check("divu_lo", 64'(lo), 64'd14);
        check("divu_hi", 64'(hi), 64'd2);
        @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
